// File: rtl/uart_tx_if.sv
// Host-side handshake and serial line of the UART transmitter.
// The master modport is the TX FIFO or host side; the slave modport is uart_tx.
interface uart_tx_if;
    logic       tx_start;
    logic [7:0] din;
    logic       tx_done_tick;
    logic       tx_busy;
    logic       tx;

    modport master (
        output tx_start,
        output din,
        input  tx_done_tick,
        input  tx_busy,
        input  tx
    );

    modport slave (
        input  tx_start,
        input  din,
        output tx_done_tick,
        output tx_busy,
        output tx
    );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: start bit, N_DATA_BITS data bits LSB first, stop period, timed by 16x s_tick.
// Optional parity bit when UART_TX_PARITY_EN is defined (adds parameter ODD_PARITY).
module uart_tx #(
    parameter int unsigned N_DATA_BITS                 = 8,
    parameter int unsigned HOW_MANY_TICKS_FOR_STOP_BIT = 16
`ifdef UART_TX_PARITY_EN
    ,
    parameter bit          ODD_PARITY                  = 1'b0
`endif
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       s_tick,
    uart_tx_if.slave   bus
);

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StStart  = 3'd1,
        StData   = 3'd2,
`ifdef UART_TX_PARITY_EN
        StParity = 3'd3,
`endif
        StStop   = 3'd4
    } state_e;

    localparam logic [4:0] BitLast  = 5'd15;
    localparam logic [4:0] StopLast = 5'(HOW_MANY_TICKS_FOR_STOP_BIT - 1);
    localparam logic [2:0] DataLast = 3'(N_DATA_BITS - 1);

    state_e                 state_q, state_d;
    logic [4:0]             s_q, s_d;
    logic [2:0]             n_q, n_d;
    logic [N_DATA_BITS-1:0] b_q, b_d;
    logic                   tx_q, tx_d;
    logic                   done;
`ifdef UART_TX_PARITY_EN
    logic                   parity_q, parity_d;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            s_q      <= '0;
            n_q      <= '0;
            b_q      <= '0;
            tx_q     <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            s_q      <= s_d;
            n_q      <= n_d;
            b_q      <= b_d;
            tx_q     <= tx_d;
`ifdef UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    // tx_d carries the level of the bit being entered, so the pin flop changes
    // on the same edge as the state register.
    always_comb begin
        state_d  = state_q;
        s_d      = s_q;
        n_d      = n_q;
        b_d      = b_q;
        tx_d     = tx_q;
        done     = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d = parity_q;
`endif
        unique case (state_q)
            StIdle: begin
                tx_d = 1'b1;
                if (bus.tx_start) begin
                    b_d      = bus.din[N_DATA_BITS-1:0];
                    s_d      = '0;
                    tx_d     = 1'b0;
                    state_d  = StStart;
`ifdef UART_TX_PARITY_EN
                    parity_d = 1'b0;
`endif
                end
            end
            StStart: begin
                tx_d = 1'b0;
                if (s_tick) begin
                    if (s_q == BitLast) begin
                        s_d     = '0;
                        n_d     = '0;
                        tx_d    = b_q[0];
                        state_d = StData;
                    end else begin
                        s_d = s_q + 5'd1;
                    end
                end
            end
            StData: begin
                if (s_tick) begin
                    if (s_q == BitLast) begin
                        s_d      = '0;
                        b_d      = b_q >> 1;
                        n_d      = n_q + 3'd1;
                        tx_d     = b_d[0];
`ifdef UART_TX_PARITY_EN
                        parity_d = parity_q ^ b_q[0];
`endif
                        if (n_q == DataLast) begin
`ifdef UART_TX_PARITY_EN
                            tx_d    = parity_d ^ ODD_PARITY;
                            state_d = StParity;
`else
                            tx_d    = 1'b1;
                            state_d = StStop;
`endif
                        end
                    end else begin
                        s_d = s_q + 5'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            StParity: begin
                if (s_tick) begin
                    if (s_q == BitLast) begin
                        s_d     = '0;
                        tx_d    = 1'b1;
                        state_d = StStop;
                    end else begin
                        s_d = s_q + 5'd1;
                    end
                end
            end
`endif
            StStop: begin
                tx_d = 1'b1;
                if (s_tick) begin
                    if (s_q == StopLast) begin
                        done    = 1'b1;
                        s_d     = '0;
                        state_d = StIdle;
                    end else begin
                        s_d = s_q + 5'd1;
                    end
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = StIdle;
            end
        endcase
    end

    assign bus.tx           = tx_q;
    assign bus.tx_busy      = (state_q != StIdle);
    assign bus.tx_done_tick = done;

endmodule

// File: tb/tb_uart_tx.sv
// Directed self-checking bench for uart_tx: an 8-bit/1-stop instance and a 5-bit/2-stop instance.
module tb_uart_tx;

    logic clk;
    logic reset_n;
    logic s_tick;
    bit   sel;
    int   checks;
    int   errors;

    uart_tx_if if8 ();
    uart_tx_if if5 ();

    uart_tx dut8 (
        .clk     (clk),
        .reset_n (reset_n),
        .s_tick  (s_tick),
        .bus     (if8.slave)
    );

    uart_tx #(
        .N_DATA_BITS                 (5),
        .HOW_MANY_TICKS_FOR_STOP_BIT (32)
    ) dut5 (
        .clk     (clk),
        .reset_n (reset_n),
        .s_tick  (s_tick),
        .bus     (if5.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic obs_tx, obs_busy, obs_done;
    always_comb begin
        obs_tx   = sel ? if5.tx           : if8.tx;
        obs_busy = sel ? if5.tx_busy      : if8.tx_busy;
        obs_done = sel ? if5.tx_done_tick : if8.tx_done_tick;
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic set_start(input logic v, input logic [7:0] d);
        if (sel) begin
            if5.tx_start = v;
            if5.din      = d;
        end else begin
            if8.tx_start = v;
            if8.din      = d;
        end
    endtask

    // Clocks with an s_tick on every fourth cycle.
    task automatic idle_clks(input int n);
        for (int i = 0; i < n; i++) begin
            s_tick = ((i % 4) == 3);
            @(posedge clk);
            #1;
        end
        s_tick = 1'b0;
    endtask

    // Sends one frame and checks tx at both ends of every bit plus done/busy timing.
    task automatic run_frame(input logic [7:0] data, input int nbits, input int stop_ticks,
                             input int div, input bit hold, input bit poke);
        logic [7:0]  mask;
        logic [10:0] ev;
        int          nb;
        int          tpb;
        int          par;
        bit          pk;
        mask = 8'((1 << nbits) - 1);
`ifdef UART_TX_PARITY_EN
        par = 1;
`else
        par = 0;
`endif
        nb = nbits + par + 2;
        ev = '0;
        ev[0] = 1'b0;
        for (int i = 0; i < nbits; i++) ev[1+i] = data[i];
        if (par == 1) ev[1+nbits] = ^(data & mask);
        ev[nb-1] = 1'b1;

        s_tick = 1'b0;
        set_start(1'b1, data);
        @(posedge clk);
        #1;
        if (!hold) set_start(1'b0, data);
        chk("accept_tx", {7'd0, obs_tx}, 8'd0);
        chk("accept_busy", {7'd0, obs_busy}, 8'd1);
        for (int k = 0; k < nb; k++) begin
            tpb = (k == nb - 1) ? stop_ticks : 16;
            for (int t = 0; t < tpb; t++) begin
                for (int c = 0; c < div; c++) begin
                    pk = poke && (k == 4) && (t == 3) && (c == 0);
                    s_tick = (c == div - 1);
                    if (pk) set_start(1'b1, 8'h00);
                    #1;
                    if (s_tick && k == nb - 1 && t == tpb - 1)
                        chk("done_hi", {7'd0, obs_done}, 8'd1);
                    if (s_tick && k == nb - 1 && t == tpb - 2)
                        chk("done_lo", {7'd0, obs_done}, 8'd0);
                    @(posedge clk);
                    #1;
                    if (pk) set_start(1'b0, 8'h00);
                    if (s_tick && t == tpb - 2) begin
                        chk($sformatf("bit%0d_end", k), {7'd0, obs_tx}, {7'd0, ev[k]});
                        chk($sformatf("bit%0d_busy", k), {7'd0, obs_busy}, 8'd1);
                    end
                    if (s_tick && t == tpb - 1) begin
                        if (k == nb - 1) begin
                            chk("after_tx", {7'd0, obs_tx}, 8'd1);
                            chk("after_busy", {7'd0, obs_busy}, 8'd0);
                        end else begin
                            chk($sformatf("bit%0d_next", k), {7'd0, obs_tx}, {7'd0, ev[k+1]});
                        end
                    end
                end
            end
        end
        s_tick = 1'b0;
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        sel         = 1'b0;
        s_tick      = 1'b0;
        reset_n     = 1'b0;
        if8.tx_start = 1'b0;
        if8.din      = 8'h00;
        if5.tx_start = 1'b0;
        if5.din      = 8'h00;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx8", {7'd0, if8.tx}, 8'd1);
        chk("rst_busy8", {7'd0, if8.tx_busy}, 8'd0);
        chk("rst_done8", {7'd0, if8.tx_done_tick}, 8'd0);
        chk("rst_tx5", {7'd0, if5.tx}, 8'd1);
        chk("rst_busy5", {7'd0, if5.tx_busy}, 8'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic 8N1 frame.
        run_frame(8'hA5, 8, 16, 4, 1'b0, 1'b0);
        idle_clks(8);

        // 5-bit, 2-stop instance: upper din bits must not leak onto the line.
        sel = 1'b1;
        run_frame(8'hFF, 5, 32, 4, 1'b0, 1'b0);
        idle_clks(8);
        run_frame(8'hE0, 5, 32, 4, 1'b0, 1'b0);
        idle_clks(8);
        chk("idle8_while5", {7'd0, if8.tx_busy}, 8'd0);
        sel = 1'b0;

        // Mid-frame tx_start with din=00 must neither alter nor queue.
        run_frame(8'h3C, 8, 16, 4, 1'b0, 1'b1);
        idle_clks(40);
        chk("poke_idle_busy", {7'd0, obs_busy}, 8'd0);
        chk("poke_idle_tx", {7'd0, obs_tx}, 8'd1);

        // tx_start held high: back-to-back frames with one idle cycle.
        run_frame(8'h55, 8, 16, 4, 1'b1, 1'b0);
        run_frame(8'hC3, 8, 16, 4, 1'b0, 1'b0);
        idle_clks(8);

        // s_tick continuously high.
        run_frame(8'h07, 8, 16, 1, 1'b0, 1'b0);
        idle_clks(8);

        // Reset during data bit 3 of 8'h00.
        set_start(1'b1, 8'h00);
        @(posedge clk);
        #1;
        set_start(1'b0, 8'h00);
        idle_clks(64 + 192 + 32);
        chk("pre_rst_tx", {7'd0, obs_tx}, 8'd0);
        chk("pre_rst_busy", {7'd0, obs_busy}, 8'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_rst_tx", {7'd0, obs_tx}, 8'd1);
        chk("async_rst_busy", {7'd0, obs_busy}, 8'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        idle_clks(100);
        chk("post_rst_tx", {7'd0, obs_tx}, 8'd1);
        chk("post_rst_busy", {7'd0, obs_busy}, 8'd0);

        run_frame(8'h5A, 8, 16, 4, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- UART transmitter; the transmit-side partner of the team's uart_rx.
- Serialises one data word per frame: 1 start bit, N_DATA_BITS data bits LSB first, optional parity, and a stop period.
- Bit timing comes from the shared baud generator's s_tick: a 16x oversample enable, one clk cycle wide.
- Sits between a TX FIFO or host logic (tx_start/din) and the UART pin.

Parameters:
- N_DATA_BITS, 8: data bits per frame; legal values 5, 6, 7, 8.
- HOW_MANY_TICKS_FOR_STOP_BIT, 16: s_ticks in the stop period; 16 = 1 stop bit, 24 = 1.5, 32 = 2.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- s_tick  input  1  16x baud enable, one clk cycle wide.
- tx_start  input  1  request to send din; honoured only in idle.
- din  input  8  data word; bits [N_DATA_BITS-1:0] are sent, upper bits are ignored.
- tx_done_tick  output  1  one-cycle pulse when the stop period completes.
- tx_busy  output  1  high in every state except idle.
- tx  output  1  serial line; driven from a flop, idle high.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - state=idle; tx=1; tx_busy=0; tx_done_tick=0; shift register=0; bit counter n=0; tick counter s=0.
  - Reset asserted mid-frame aborts the frame immediately; tx returns high with no glitch low.
- States: idle, start, data, parity (only with the optional feature), stop. Encode state in 3 bits.
- idle:
  - tx=1.
  - If tx_start=1: capture din into the shift register, set s=0, go to start.
  - tx goes low on the clk edge that accepts tx_start (tx is visible low the cycle after tx_start).
- start:
  - tx=0.
  - On each s_tick, s increments.
  - On the s_tick where s==15: set s=0, n=0, go to data. The start bit lasts exactly 16 s_ticks.
- data:
  - tx = shift register bit 0.
  - On the s_tick where s==15: set s=0, shift right by one, n=n+1.
  - When n==N_DATA_BITS-1 on that tick, go to stop (or to parity if enabled). Each data bit lasts 16 s_ticks.
- stop:
  - tx=1.
  - On the s_tick where s==HOW_MANY_TICKS_FOR_STOP_BIT-1: tx_done_tick=1 for that single cycle, go to idle.
  - The s counter is 5 bits so that 32 ticks is representable.
- Handshake:
  - tx_start is ignored whenever tx_busy=1; no queueing.
  - tx_start in the same cycle as tx_done_tick is also ignored.
  - The earliest next accept is the cycle after tx_done_tick, giving back-to-back frames with no idle gap beyond that single cycle.
  - din is sampled only in the accept cycle; changes to din afterwards do not affect the frame.
- Cycles without s_tick hold all state. s_tick held high continuously is legal: the frame then runs at 1 bit per 16 clk.
- Frame length in s_ticks: 16*(1+N_DATA_BITS) + HOW_MANY_TICKS_FOR_STOP_BIT, plus 16 with parity enabled.
- tx_done_tick is combinational from state/s/s_tick (Moore/Mealy mix, same style as the receiver). tx_busy is decoded from state_reg.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - Adds parameter ODD_PARITY (default 0), the parity state, and a parity register.
  - The parity register is XOR-accumulated with each transmitted data bit.
  - After the last data bit, parity is sent for 16 s_ticks.
  - Parity bit value: even parity = XOR of data bits; odd parity = its inverse.
  - The parity state then moves to stop.
- Undefined:
  - No parity state, register, or parameter.
  - data goes directly to stop.

Test Plan:
- Reset, then s_tick every 4 clk, din=8'hA5, tx_start for 1 cycle:
  - tx line is 0, then 1,0,1,0,0,1,0,1 (LSB first), then 1.
  - Each bit is 16 s_ticks (64 clk).
  - tx_done_tick pulses once at s_tick 160; tx_busy is high from the cycle after tx_start until idle.
- N_DATA_BITS=5, HOW_MANY_TICKS_FOR_STOP_BIT=32, din=8'hFF:
  - Frame is start, five 1s, 32-tick stop; total 128 s_ticks.
  - Upper 3 din bits never appear on tx.
- tx_start pulsed mid-frame with din=8'h00 while sending 8'h3C:
  - Frame for 8'h3C completes unaltered; no second frame starts.
- tx_start held high continuously, din=8'h55 then 8'hC3 at the accept points:
  - Two frames, separated only by the single idle cycle after tx_done_tick; both words transmitted correctly.
- reset_n driven low during data bit 3 of 8'h00:
  - tx goes to 1 asynchronously; tx_busy=0.
  - After release, tx stays 1 until a new tx_start.
- With UART_TX_PARITY_EN and ODD_PARITY=0, din=8'h07:
  - Parity bit is 1 for 16 ticks, followed by stop.
  - With ODD_PARITY=1, the parity bit is 0.
